pulse_timer_arbiter: RTL and testbench



---
 rtl/pulse_arb_pkg.sv | 19 +
 rtl/pulse_timer_arbiter_rr_pick.sv | 60 ++++++
 rtl/pulse_timer_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_pulse_timer_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_arb_pkg.sv
// pulse_arb_pkg: shared definitions for the pulse timer arbiter.
//   state_e         - arbiter FSM state encoding
//   DEF_PERIOD_W    - default width of periods / pulse_time
//   DEF_TICKS_W     - default width of requested tick counts
//   DEF_MIN_PERIOD  - smallest period ever forwarded to the timer
package pulse_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int          DEF_PERIOD_W   = 32;
  localparam int          DEF_TICKS_W    = 16;
  localparam logic [31:0] DEF_MIN_PERIOD = 32'd2;

endpackage

// File: rtl/pulse_timer_arbiter_rr_pick.sv
// rr_pick: combinational winner selection for the pulse timer arbiter.
//   req    in  NUM_REQ  request vector
//   ptr    in  IDX_W    round-robin start index
//   winner out NUM_REQ  one-hot winner (zero when no request)
//   valid  out 1        at least one request present
// Build option: PULSE_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, ptr ignored) instead of round-robin starting at ptr.
module rr_pick
  import pulse_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

`ifdef PULSE_ARB_FIXED_PRIO_EN
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;

  // Fixed priority: the first set bit from index 0 upward wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i]) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end
`else
  int sum_s;
  int idx_s;

  // Round-robin: scan from ptr upward, wrapping modulo NUM_REQ.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum_s  = 0;
    idx_s  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = int'(ptr) + k;
      idx_s = (sum_s >= NUM_REQ) ? (sum_s - NUM_REQ) : sum_s;
      if (!valid && req[IDX_W'(idx_s)]) begin
        winner[IDX_W'(idx_s)] = 1'b1;
        valid                 = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end
`endif

endmodule

// File: rtl/pulse_timer_arbiter.sv
// pulse_timer_arbiter: shares one programmable pulse timer among NUM_REQ
// requesters. The granted requester's (clamped) period is driven onto
// pulse_time, the timer is restarted once per grant, and timer ticks are
// counted until the requested count is reached, then done pulses and the
// timer is released.
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   req          in   level requests, one per requester
//   req_period   in   packed periods, slice i for req[i]
//   req_ticks    in   packed tick counts, slice i for req[i]
//   grant        out  one-hot owner, zero when idle
//   done         out  one-clock completion pulse to the owner
//   busy         out  grant is non-zero
//   pulse_time   out  period driven to the timer
//   timer_rst_n  out  active-low timer restart, low one cycle per grant
//   tick_in      in   one-clock tick strobe from the timer
//   tick_cnt     out  ticks counted for the current owner
// Build option: PULSE_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
//
// Outputs are registered. The values belonging to LOAD (restart low, count
// cleared, period applied, zero-tick done) are loaded on the arbitration edge
// so they are visible during the LOAD cycle; grant/busy clear on the edge that
// leaves RELEASE, so done is always seen together with the owner's grant.
module pulse_timer_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int                NUM_REQ    = 4,
  parameter int                PERIOD_W   = DEF_PERIOD_W,
  parameter int                TICKS_W    = DEF_TICKS_W,
  parameter logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(DEF_MIN_PERIOD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*PERIOD_W-1:0] req_period,
  input  logic [NUM_REQ*TICKS_W-1:0]  req_ticks,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic [PERIOD_W-1:0]     pulse_time,
  output logic                    timer_rst_n,
  input  logic                    tick_in,
  output logic [TICKS_W-1:0]      tick_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic [PERIOD_W-1:0]  pulse_time_q, pulse_time_d;
  logic                 timer_rst_n_q, timer_rst_n_d;
  logic [TICKS_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [TICKS_W-1:0]   ticks_q, ticks_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;

  logic [NUM_REQ-1:0]   win_oh_s;
  logic                 win_valid_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic [PERIOD_W-1:0]  sel_period_s;
  logic [TICKS_W-1:0]   sel_ticks_s;
  logic [PERIOD_W-1:0]  clamped_period_s;
  logic [TICKS_W-1:0]   tick_cnt_inc_s;
  logic                 last_tick_s;
  logic                 owner_req_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (win_oh_s),
    .valid  (win_valid_s)
  );

  // Decode the winner index and pick out its period and tick count.
  always_comb begin
    win_idx_s    = '0;
    sel_period_s = '0;
    sel_ticks_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh_s[i]) begin
        win_idx_s    = IDX_W'(i);
        sel_period_s = req_period[i*PERIOD_W +: PERIOD_W];
        sel_ticks_s  = req_ticks[i*TICKS_W +: TICKS_W];
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  assign clamped_period_s = (sel_period_s < MIN_PERIOD) ? MIN_PERIOD : sel_period_s;
  assign tick_cnt_inc_s   = tick_cnt_q + TICKS_W'(1);
  assign last_tick_s      = (tick_cnt_inc_s == ticks_q);
  assign owner_req_s      = req[owner_q];

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    done_d        = '0;
    busy_d        = busy_q;
    pulse_time_d  = pulse_time_q;
    timer_rst_n_d = timer_rst_n_q;
    tick_cnt_d    = tick_cnt_q;
    ticks_d       = ticks_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          grant_d       = win_oh_s;
          busy_d        = 1'b1;
          owner_d       = win_idx_s;
          pulse_time_d  = clamped_period_s;
          ticks_d       = sel_ticks_s;
          tick_cnt_d    = '0;
          timer_rst_n_d = 1'b0;
          if (sel_ticks_s == '0) begin
            done_d = win_oh_s;
          end else begin
            done_d = '0;
          end
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        timer_rst_n_d = 1'b1;
        if (ticks_q == '0) begin
          state_d = RELEASE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick_in) begin
          tick_cnt_d = tick_cnt_inc_s;
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
        // A tick coinciding with a dropped request still counts and may finish.
        if (tick_in && last_tick_s) begin
          done_d  = grant_q;
          state_d = RELEASE;
        end else if (!owner_req_s) begin
          state_d = RELEASE;
        end else begin
          state_d = RUN;
        end
      end
      RELEASE: begin
        grant_d = '0;
        busy_d  = 1'b0;
`ifdef PULSE_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        if (int'(owner_q) == NUM_REQ - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = owner_q + IDX_W'(1);
        end
`endif
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      done_q        <= '0;
      busy_q        <= 1'b0;
      pulse_time_q  <= MIN_PERIOD;
      timer_rst_n_q <= 1'b1;
      tick_cnt_q    <= '0;
      ticks_q       <= '0;
      owner_q       <= '0;
      ptr_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      pulse_time_q  <= pulse_time_d;
      timer_rst_n_q <= timer_rst_n_d;
      tick_cnt_q    <= tick_cnt_d;
      ticks_q       <= ticks_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign pulse_time  = pulse_time_q;
  assign timer_rst_n = timer_rst_n_q;
  assign tick_cnt    = tick_cnt_q;

endmodule

// File: tb/tb_pulse_timer_arbiter.sv
// Self-checking bench for pulse_timer_arbiter: directed table, hand-written
// corner sequences and randomized transactions checked against a
// transaction-level reference (winner search, clamp, tick budget).
module tb_pulse_timer_arbiter;

  localparam int N  = 4;
  localparam int PW = 32;
  localparam int TW = 16;
  localparam logic [PW-1:0] MINP = 32'd2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*PW-1:0]   req_period;
  logic [N*TW-1:0]   req_ticks;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic              busy;
  logic [PW-1:0]     pulse_time;
  logic              timer_rst_n;
  logic              tick_in;
  logic [TW-1:0]     tick_cnt;

  int checks   = 0;
  int failures = 0;
  int mptr     = 0;

  always #5 clk = ~clk;

  pulse_timer_arbiter #(.NUM_REQ(N), .PERIOD_W(PW), .TICKS_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_period  (req_period),
    .req_ticks   (req_ticks),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .pulse_time  (pulse_time),
    .timer_rst_n (timer_rst_n),
    .tick_in     (tick_in),
    .tick_cnt    (tick_cnt)
  );

  typedef struct {
    logic [N-1:0]  r;
    logic [PW-1:0] per;
    logic [TW-1:0] tk;
    logic [N-1:0]  eg;
    logic [PW-1:0] ept;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
    chk("done_only_owner", 64'(done & ~grant), 64'd0);
  endtask

  task automatic set_all(input logic [PW-1:0] per, input logic [TW-1:0] tk);
    for (int i = 0; i < N; i++) begin
      req_period[i*PW +: PW] = per;
      req_ticks[i*TW +: TW]  = tk;
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    int idx;
`ifdef PULSE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (r[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  function automatic int next_ptr(input int w);
`ifdef PULSE_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (w + 1) % N;
`endif
  endfunction

  function automatic logic [PW-1:0] clampv(input logic [PW-1:0] p);
    return (p < MINP) ? MINP : p;
  endfunction

  // One complete transaction with a tick every RUN cycle.
  task automatic run_txn(input string nm, input logic [N-1:0] r, input logic [PW-1:0] per,
                         input logic [TW-1:0] tk, input logic [N-1:0] eg, input logic [PW-1:0] ept);
    int w;
    int cyc;
    logic [N-1:0] got;
    w = pick(r, mptr);
    req = r;
    set_all(per, tk);
    tick_in = 1'b0;
    step();
    chk({nm, "_grant"}, 64'(grant), 64'(eg));
    chk({nm, "_pulse_time"}, 64'(pulse_time), 64'(ept));
    chk({nm, "_timer_rst_low"}, 64'(timer_rst_n), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    chk({nm, "_done_load"}, 64'(done), (tk == '0) ? 64'(eg) : 64'd0);
    tick_in = 1'b1;
    step();
    chk({nm, "_timer_rst_high"}, 64'(timer_rst_n), 64'd1);
    chk({nm, "_load_tick_ignored"}, 64'(tick_cnt), 64'd0);
    if (tk != '0) begin
      got = '0;
      for (cyc = 0; cyc < int'(tk) + 4 && got == '0; cyc++) begin
        step();
        got = done;
      end
      chk({nm, "_done"}, 64'(got), 64'(eg));
      chk({nm, "_ticks_to_done"}, 64'(cyc), 64'(tk));
      chk({nm, "_tick_cnt"}, 64'(tick_cnt), 64'(tk));
    end
    step();
    chk({nm, "_rel_grant"}, 64'(grant), 64'd0);
    chk({nm, "_rel_busy"}, 64'(busy), 64'd0);
    chk({nm, "_rel_tick_cnt"}, 64'(tick_cnt), 64'(tk));
    tick_in = 1'b0;
    mptr = next_ptr(w);
  endtask

  initial begin
    int w;
    int other;
    int nt;
    int cnt;
    int cyc;
    int drop_pt;
    bit t;
    bit d;
    bit fin;
    bit ended;
    logic [N-1:0]  r;
    logic [PW-1:0] pers [N];
    logic [TW-1:0] tks [N];

    // ---------------- reset ----------------
    rst_n = 1'b0;
    req = '0;
    set_all('0, '0);
    tick_in = 1'b1;
    step();
    step();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulse_time", 64'(pulse_time), 64'(MINP));
    chk("rst_timer_rst_n", 64'(timer_rst_n), 64'd1);
    chk("rst_tick_cnt", 64'(tick_cnt), 64'd0);
    rst_n = 1'b1;
    tick_in = 1'b0;
    mptr = 0;
    step();
    chk("idle_no_grant", 64'(grant), 64'd0);

    // ---------------- directed table ----------------
`ifdef PULSE_ARB_FIXED_PRIO_EN
    vt[0] = '{4'b1111, 32'd10, 16'd1, 4'b0001, 32'd10};
    vt[1] = '{4'b1111, 32'd10, 16'd1, 4'b0001, 32'd10};
    vt[2] = '{4'b1111, 32'd10, 16'd1, 4'b0001, 32'd10};
    vt[3] = '{4'b1111, 32'd10, 16'd1, 4'b0001, 32'd10};
    vt[4] = '{4'b1111, 32'd10, 16'd1, 4'b0001, 32'd10};
`else
    vt[0] = '{4'b1111, 32'd10, 16'd1, 4'b0001, 32'd10};
    vt[1] = '{4'b1111, 32'd10, 16'd1, 4'b0010, 32'd10};
    vt[2] = '{4'b1111, 32'd10, 16'd1, 4'b0100, 32'd10};
    vt[3] = '{4'b1111, 32'd10, 16'd1, 4'b1000, 32'd10};
    vt[4] = '{4'b1111, 32'd10, 16'd1, 4'b0001, 32'd10};
`endif
    vt[5] = '{4'b0001, 32'd0,          16'd2, 4'b0001, 32'd2};
    vt[6] = '{4'b0001, 32'd1,          16'd1, 4'b0001, 32'd2};
    vt[7] = '{4'b0100, 32'd2,          16'd3, 4'b0100, 32'd2};
    vt[8] = '{4'b1000, 32'hFFFF_FFFF,  16'd1, 4'b1000, 32'hFFFF_FFFF};
    vt[9] = '{4'b0010, 32'd5,          16'd0, 4'b0010, 32'd5};
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vt[i].r, vt[i].per, vt[i].tk, vt[i].eg, vt[i].ept);
    end

    // ---------------- single request, sparse ticks ----------------
    req = 4'b0001;
    set_all(32'd10, 16'd3);
    tick_in = 1'b0;
    step();
    chk("single_grant", 64'(grant), 64'd1);
    chk("single_rst_low", 64'(timer_rst_n), 64'd0);
    step();
    chk("single_rst_one_cycle", 64'(timer_rst_n), 64'd1);
    nt = 0;
    for (int c = 0; c < 6; c++) begin
      tick_in = (c % 2) == 1;
      step();
      if (c % 2 == 1) nt++;
      chk("single_tick_cnt", 64'(tick_cnt), 64'(nt));
      chk("single_done", 64'(done), (nt == 3 && c % 2 == 1) ? 64'd1 : 64'd0);
      chk("single_busy", 64'(busy), 64'd1);
    end
    tick_in = 1'b0;
    step();
    chk("single_busy_drop", 64'(busy), 64'd0);
    chk("single_done_once", 64'(done), 64'd0);
    mptr = next_ptr(0);

    // ---------------- latch + abandon, then drop on final tick ----------------
    r = 4'b0011;
    req = r;
    set_all(32'd7, 16'd5);
    w = pick(r, mptr);
    other = (w == 0) ? 1 : 0;
    step();
    chk("ab_grant", 64'(grant), 64'(1 << w));
    chk("ab_pulse7", 64'(pulse_time), 64'd7);
    set_all(32'd99, 16'd1);
    step();
    tick_in = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("ab_no_done", 64'(done), 64'd0);
      chk("ab_pulse_latched", 64'(pulse_time), 64'd7);
    end
    tick_in = 1'b0;
    req[w] = 1'b0;
    step();
    chk("ab_drop_done", 64'(done), 64'd0);
    chk("ab_tick_cnt_stop", 64'(tick_cnt), 64'd2);
    step();
    chk("ab_release", 64'(grant), 64'd0);
    chk("ab_release_done", 64'(done), 64'd0);
    mptr = next_ptr(w);
    set_all(32'd99, 16'd5);
    step();
    chk("ab_next_grant", 64'(grant), 64'(1 << other));
    chk("ab_next_pulse", 64'(pulse_time), 64'd99);
    step();
    tick_in = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("fin_cnt", 64'(tick_cnt), 64'(c));
      chk("fin_no_done", 64'(done), 64'd0);
    end
    req = '0;
    step();
    chk("fin_drop_done", 64'(done), 64'(1 << other));
    chk("fin_cnt5", 64'(tick_cnt), 64'd5);
    tick_in = 1'b0;
    step();
    chk("fin_release", 64'(grant), 64'd0);
    mptr = next_ptr(other);

    // ---------------- sync reset in RUN ----------------
    r = 4'b0011;
    req = r;
    set_all(32'd10, 16'd6);
    w = pick(r, mptr);
    step();
    chk("rr_pre_grant", 64'(grant), 64'(1 << w));
    step();
    tick_in = 1'b1;
    step();
    chk("rr_pre_cnt", 64'(tick_cnt), 64'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_grant", 64'(grant), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_pulse", 64'(pulse_time), 64'(MINP));
    chk("mid_rst_trst", 64'(timer_rst_n), 64'd1);
    chk("mid_rst_cnt", 64'(tick_cnt), 64'd0);
    rst_n = 1'b1;
    tick_in = 1'b0;
    mptr = 0;
    step();
    chk("post_rst_grant0", 64'(grant), 64'd1);
    req = '0;
    step();
    step();
    chk("post_rst_no_done", 64'(done), 64'd0);
    step();
    chk("post_rst_release", 64'(grant), 64'd0);
    mptr = next_ptr(0);

    // ---------------- randomized transactions ----------------
    for (int it = 0; it < 150; it++) begin
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: pers[i] = 32'd0;
          1: pers[i] = 32'd1;
          2: pers[i] = 32'd2;
          default: pers[i] = 32'($urandom_range(3, 1000));
        endcase
        tks[i] = 16'($urandom_range(0, 4));
        req_period[i*PW +: PW] = pers[i];
        req_ticks[i*TW +: TW]  = tks[i];
      end
      req = r;
      tick_in = 1'($urandom_range(0, 1));
      w = pick(r, mptr);
      step();
      chk("rnd_grant", 64'(grant), 64'(1 << w));
      chk("rnd_busy", 64'(busy), 64'd1);
      chk("rnd_trst_low", 64'(timer_rst_n), 64'd0);
      chk("rnd_pulse", 64'(pulse_time), 64'(clampv(pers[w])));
      chk("rnd_cnt0", 64'(tick_cnt), 64'd0);
      chk("rnd_done_zero", 64'(done), (tks[w] == '0) ? 64'(1 << w) : 64'd0);
      for (int i = 0; i < N; i++) begin
        req_period[i*PW +: PW] = 32'($urandom);
        req_ticks[i*TW +: TW]  = 16'($urandom_range(1, 3));
      end
      tick_in = 1'($urandom_range(0, 1));
      step();
      chk("rnd_trst_high", 64'(timer_rst_n), 64'd1);
      chk("rnd_load_cnt", 64'(tick_cnt), 64'd0);
      chk("rnd_load_done", 64'(done), 64'd0);
      cnt = 0;
      cyc = 0;
      drop_pt = $urandom_range(0, 6);
      ended = (tks[w] == '0);
      while (!ended) begin
        t = ($urandom_range(0, 3) != 0);
        d = ((cnt >= drop_pt) && ($urandom_range(0, 1) == 1)) || (cyc >= 30);
        tick_in = t;
        if (d) req[w] = 1'b0;
        step();
        if (t) cnt++;
        fin = t && (cnt == int'(tks[w]));
        chk("rnd_done", 64'(done), fin ? 64'(1 << w) : 64'd0);
        chk("rnd_cnt", 64'(tick_cnt), 64'(cnt));
        chk("rnd_pulse_hold", 64'(pulse_time), 64'(clampv(pers[w])));
        chk("rnd_owner", 64'(grant), 64'(1 << w));
        ended = fin || d;
        cyc++;
      end
      tick_in = 1'($urandom_range(0, 1));
      step();
      chk("rnd_rel_grant", 64'(grant), 64'd0);
      chk("rnd_rel_busy", 64'(busy), 64'd0);
      chk("rnd_rel_done", 64'(done), 64'd0);
      chk("rnd_rel_cnt", 64'(tick_cnt), 64'(cnt));
      mptr = next_ptr(w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
